audio_pair_sched: RTL and testbench

AUDIO_PAIR_SCHED -- requirements
Module: audio_pair_sched

---
 rtl/audio_pair_sched_if.sv | 25 ++
 rtl/audio_pair_sched.sv | 80 ++++++++
 tb/tb_audio_pair_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pair_sched_if.sv
// Handshake bundle between the pair scheduler, its two show-ahead input FIFOs
// and the interleaved output FIFO.
interface audio_pair_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  left_empty;
  logic [DATA_WIDTH-1:0] left_dout;
  logic                  left_rd_en;
  logic                  right_empty;
  logic [DATA_WIDTH-1:0] right_dout;
  logic                  right_rd_en;
  logic                  out_full;
  logic                  out_wr_en;
  logic [DATA_WIDTH-1:0] out_din;

  modport master (
    input  left_empty, left_dout, right_empty, right_dout, out_full,
    output left_rd_en, right_rd_en, out_wr_en, out_din
  );

  modport slave (
    output left_empty, left_dout, right_empty, right_dout, out_full,
    input  left_rd_en, right_rd_en, out_wr_en, out_din
  );
endinterface

// File: rtl/audio_pair_sched.sv
// Paced stereo interleaver: on each period tick pops one left/right pair
// together and writes them to the output FIFO as L then R.
module audio_pair_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int PERIOD_WIDTH = 16,
  parameter int LATE_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  audio_pair_sched_if.master      bus,
  output logic                    busy,
  output logic [LATE_WIDTH-1:0]   late_count
);

  typedef enum logic [1:0] {IDLE, WR_L, WR_R} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] reload;
  logic                    pending;
  logic                    tick;
  logic                    pop;
  logic                    wr;
  logic                    clr;
  logic [DATA_WIDTH-1:0]   hold_l;
  logic [DATA_WIDTH-1:0]   hold_r;

  // period 0 behaves as period 1: the counter parks at 0 and ticks every cycle
  assign tick   = enable && (cnt == '0);
  assign reload = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);

  assign pop = (state == IDLE) && pending && !bus.left_empty && !bus.right_empty;
  assign wr  = ((state == WR_L) || (state == WR_R)) && !bus.out_full;
  assign clr = (state == WR_R) && wr;

  assign bus.left_rd_en  = pop;
  assign bus.right_rd_en = pop;
  assign bus.out_wr_en   = wr;
  assign busy            = (state != IDLE);

  always_comb begin
    bus.out_din = '0;
    if (wr) bus.out_din = (state == WR_L) ? hold_l : hold_r;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      late_count <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
    end else begin
      if (tick)                      cnt <= reload;
      else if (enable && cnt != '0)  cnt <= cnt - PERIOD_WIDTH'(1);

      // a tick landing on the clearing write keeps the next pair pending
      if (tick)     pending <= 1'b1;
      else if (clr) pending <= 1'b0;

      if (tick && pending && !clr && late_count != '1)
        late_count <= late_count + LATE_WIDTH'(1);

      case (state)
        IDLE: if (pop) begin
          hold_l <= bus.left_dout;
          hold_r <= bus.right_dout;
          state  <= WR_L;
        end
        WR_L:    if (wr) state <= WR_R;
        WR_R:    if (wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_pair_sched.sv
// Randomised and directed bench for audio_pair_sched against a cycle-level
// behavioural model of the pacing, pending and pair-write rules.
module tb_audio_pair_sched;
  localparam int DW = 32;
  localparam int PW = 16;
  localparam int LW = 4;
  localparam int LATE_MAX = (1 << LW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic          busy;
  logic [LW-1:0] late_count;

  audio_pair_sched_if #(.DATA_WIDTH(DW)) bus ();

  audio_pair_sched #(.DATA_WIDTH(DW), .PERIOD_WIDTH(PW), .LATE_WIDTH(LW)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .period     (period),
    .bus        (bus.master),
    .busy       (busy),
    .late_count (late_count)
  );

  always #5 clock = ~clock;

  // environment FIFOs and observed output stream
  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] obs[$];
  logic          full;

  // reference model state
  int            m_wait;   // enabled cycles left before the next tick
  bit            m_pend;
  int            m_late;
  int            m_step;   // 0 no pair held, 1 left owed, 2 right owed
  logic [DW-1:0] m_hl;
  logic [DW-1:0] m_hr;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.left_empty  = (lq.size() == 0);
    bus.left_dout   = (lq.size() != 0) ? lq[0] : '0;
    bus.right_empty = (rq.size() == 0);
    bus.right_dout  = (rq.size() != 0) ? rq[0] : '0;
    bus.out_full    = full;
  endtask

  task automatic model_clear();
    m_wait = 0; m_pend = 0; m_late = 0; m_step = 0; m_hl = '0; m_hr = '0;
  endtask

  // one clock: entered and left just after a falling edge
  task automatic step();
    bit tick, erd, ewr, clr, dl, dr;
    logic [DW-1:0] edin;
    int rl;
    refresh();
    #1;
    tick = enable && (m_wait == 0);
    erd  = (m_step == 0) && m_pend && lq.size() > 0 && rq.size() > 0;
    ewr  = (m_step != 0) && !full;
    edin = !ewr ? '0 : (m_step == 1 ? m_hl : m_hr);
    chk("left_rd_en",  bus.left_rd_en,  erd);
    chk("right_rd_en", bus.right_rd_en, erd);
    chk("out_wr_en",   bus.out_wr_en,   ewr);
    chk("out_din",     bus.out_din,     edin);
    chk("busy",        busy,            m_step != 0);
    chk("late_count",  late_count,      m_late);
    if (bus.out_wr_en) obs.push_back(bus.out_din);
    dl = bus.left_rd_en;
    dr = bus.right_rd_en;
    @(posedge clock);
    #1;
    clr = (m_step == 2) && ewr;
    rl  = (period == 0) ? 0 : int'(period) - 1;
    if (tick) m_wait = rl;
    else if (enable && m_wait > 0) m_wait--;
    if (tick && m_pend && !clr && m_late < LATE_MAX) m_late++;
    if (tick) m_pend = 1;
    else if (clr) m_pend = 0;
    if (erd) begin
      m_hl = lq[0]; m_hr = rq[0]; m_step = 1;
    end else if (ewr) begin
      m_step = (m_step == 1) ? 2 : 0;
    end
    if (dl && lq.size() > 0) void'(lq.pop_front());
    if (dr && rq.size() > 0) void'(rq.pop_front());
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lq.delete(); rq.delete(); obs.delete();
    full = 1'b0;
    refresh();
    @(negedge clock);
    #1;
    chk("rst_wr_en",  bus.out_wr_en,   1'b0);
    chk("rst_rd_l",   bus.left_rd_en,  1'b0);
    chk("rst_rd_r",   bus.right_rd_en, 1'b0);
    chk("rst_din",    bus.out_din,     '0);
    chk("rst_busy",   busy,            1'b0);
    chk("rst_late",   late_count,      '0);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lq.push_back(l);
    rq.push_back(r);
  endtask

  initial begin
    full = 1'b0;
    model_clear();
    refresh();

    // scenario 1: steady pacing, period 4
    period = 4; enable = 1'b1;
    do_reset();
    push_pair(32'h11, 32'h21); push_pair(32'h12, 32'h22); push_pair(32'h13, 32'h23);
    steps(16);
    chk("s1_count", obs.size(), 6);
    if (obs.size() == 6) begin
      chk("s1_w0", obs[0], 32'h11); chk("s1_w1", obs[1], 32'h21);
      chk("s1_w2", obs[2], 32'h12); chk("s1_w3", obs[3], 32'h22);
      chk("s1_w4", obs[4], 32'h13); chk("s1_w5", obs[5], 32'h23);
    end

    // scenario 2: right starved, late ticks accumulate
    period = 2;
    do_reset();
    lq.push_back(32'hA0); lq.push_back(32'hA1); lq.push_back(32'hA2);
    steps(10);
    chk("s2_late", late_count, 4);
    rq.push_back(32'hB0);
    steps(6);
    chk("s2_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("s2_w0", obs[0], 32'hA0); chk("s2_w1", obs[1], 32'hB0);
    end

    // scenario 3: output back-pressure while the left word is owed
    period = 100;
    do_reset();
    push_pair(32'h31, 32'h41);
    steps(2);
    full = 1'b1; steps(5);
    chk("s3_none_yet", obs.size(), 0);
    full = 1'b0; steps(3);
    chk("s3_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("s3_w0", obs[0], 32'h31); chk("s3_w1", obs[1], 32'h41);
    end

    // scenario 4: period 0, back-to-back pairs, late_count saturates
    period = 0;
    do_reset();
    for (int i = 0; i < 8; i++) push_pair(32'h100 + i, 32'h200 + i);
    steps(30);
    chk("s4_count", obs.size(), 16);
    chk("s4_late_sat", late_count, LATE_MAX);

    // scenario 5: asynchronous reset while the right word is owed
    period = 100;
    do_reset();
    push_pair(32'h51, 32'h61);
    steps(3);
    full = 1'b1; steps(1);
    refresh();
    #2 reset = 1'b1;
    #1;
    chk("s5_wr_en", bus.out_wr_en, 1'b0);
    chk("s5_din",   bus.out_din,   '0);
    chk("s5_busy",  busy,          1'b0);
    chk("s5_late",  late_count,    '0);
    chk("s5_left_only", obs.size(), 1);
    @(negedge clock);
    do_reset();
    steps(6);
    chk("s5_no_right", obs.size(), 0);

    // scenario 6: enable dropped while the left word is owed
    period = 3;
    do_reset();
    push_pair(32'h71, 32'h81); push_pair(32'h72, 32'h82); push_pair(32'h73, 32'h83);
    steps(2);
    enable = 1'b0;
    steps(10);
    chk("s6_count", obs.size(), 2);
    chk("s6_left_kept", lq.size(), 2);
    enable = 1'b1;

    // randomised traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) period = PW'($urandom_range(0, 5));
      enable = ($urandom_range(0, 9) < 8);
      full   = ($urandom_range(0, 3) == 0);
      if (lq.size() < 6 && $urandom_range(0, 2) == 0) lq.push_back($urandom);
      if (rq.size() < 6 && $urandom_range(0, 2) == 0) rq.push_back($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
